// File: rtl/load_store_unit.sv
// load_store_unit: turns byte-addressed load/store requests from the MEM
// stage into word accesses on a word-indexed data memory. Handles byte,
// halfword and word sizes, sign/zero extension on loads, read-modify-write
// for sub-word stores, and flags misaligned or reserved-size requests
// without touching memory.
module load_store_unit #(
    parameter int unsigned IDX_W = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_write_signal,
    output logic        mem_read_signal,
    output logic [31:0] mem_address,
    output logic [31:0] mem_dataIn,
    input  logic [31:0] mem_dataOut
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WRITE,
        RMW_READ,
        RMW_WRITE
    } state_t;

    state_t             state;

    // Request fields captured at acceptance
    logic [IDX_W-1:0]   l_idx;
    logic [1:0]         l_lane;
    logic [1:0]         l_size;
    logic               l_unsigned;
    logic [31:0]        l_wdata;   // store data; holds the merged word in RMW_WRITE

    logic               req_bad;
    logic [7:0]         lane_byte;
    logic [15:0]        lane_half;
    logic [31:0]        load_ext;
    logic [31:0]        merged;

    // Address bits above the forwarded word index alias onto the same words
    logic               unused_addr_hi;
    assign unused_addr_hi = ^req_addr[31:IDX_W+2];

    assign req_ready = (state == IDLE);

    // Reject misaligned halfword/word requests and the reserved size code
    always_comb begin
        req_bad = 1'b0;
        if (req_size == SZ_RSVD)
            req_bad = 1'b1;
        else if (req_size == SZ_HALF && req_addr[0])
            req_bad = 1'b1;
        else if (req_size == SZ_WORD && req_addr[1:0] != 2'b00)
            req_bad = 1'b1;
    end

    // Lane extraction with extension for loads, and lane merge for sub-word stores
    always_comb begin
        case (l_lane)
            2'd0:    lane_byte = mem_dataOut[7:0];
            2'd1:    lane_byte = mem_dataOut[15:8];
            2'd2:    lane_byte = mem_dataOut[23:16];
            default: lane_byte = mem_dataOut[31:24];
        endcase
        lane_half = l_lane[1] ? mem_dataOut[31:16] : mem_dataOut[15:0];

        case (l_size)
            SZ_BYTE: load_ext = l_unsigned ? {24'h000000, lane_byte}
                                           : {{24{lane_byte[7]}}, lane_byte};
            SZ_HALF: load_ext = l_unsigned ? {16'h0000, lane_half}
                                           : {{16{lane_half[15]}}, lane_half};
            default: load_ext = mem_dataOut;
        endcase

        merged = mem_dataOut;
        if (l_size == SZ_BYTE) begin
            case (l_lane)
                2'd0:    merged[7:0]   = l_wdata[7:0];
                2'd1:    merged[15:8]  = l_wdata[7:0];
                2'd2:    merged[23:16] = l_wdata[7:0];
                default: merged[31:24] = l_wdata[7:0];
            endcase
        end else if (l_lane[1]) begin
            merged[31:16] = l_wdata[15:0];
        end else begin
            merged[15:0] = l_wdata[15:0];
        end
    end

    // Memory interface decoded only from state and latched request
    always_comb begin
        mem_write_signal = 1'b0;
        mem_read_signal  = 1'b0;
        mem_address      = '0;
        mem_dataIn       = '0;
        case (state)
            READ, RMW_READ: begin
                mem_read_signal = 1'b1;
                mem_address     = {{(32-IDX_W){1'b0}}, l_idx};
            end
            WRITE, RMW_WRITE: begin
                mem_write_signal = 1'b1;
                mem_address      = {{(32-IDX_W){1'b0}}, l_idx};
                mem_dataIn       = l_wdata;
            end
            default: ;
        endcase
    end

    // Control FSM with registered response outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
            l_idx      <= '0;
            l_lane     <= '0;
            l_size     <= '0;
            l_unsigned <= 1'b0;
            l_wdata    <= '0;
        end else begin
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        l_idx      <= req_addr[IDX_W+1:2];
                        l_lane     <= req_addr[1:0];
                        l_size     <= req_size;
                        l_unsigned <= req_unsigned;
                        l_wdata    <= req_wdata;
                        if (req_bad) begin
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (!req_write) begin
                            state <= READ;
                        end else if (req_size == SZ_WORD) begin
                            state <= WRITE;
                        end else begin
                            state <= RMW_READ;
                        end
                    end
                end
                READ: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= load_ext;
                    state      <= IDLE;
                end
                WRITE: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    state      <= IDLE;
                end
                RMW_READ: begin
                    l_wdata <= merged;
                    state   <= RMW_WRITE;
                end
                RMW_WRITE: begin
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
